// File: rtl/ice51_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ice51_loader_if
// Description : Program-memory write port from the boot loader to the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface ice51_loader_if #(
    parameter int AW = 9
);
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    o_mem_data;
    logic          o_mem_we;
    logic          o_load_done;
    logic          o_frame_err;

    modport master (
        output o_mem_addr,
        output o_mem_data,
        output o_mem_we,
        output o_load_done,
        output o_frame_err
    );

    modport slave (
        input o_mem_addr,
        input o_mem_data,
        input o_mem_we,
        input o_load_done,
        input o_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ice51_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ice51_loader
// Description : 8N1 UART receiver that fills program memory from address 0
//               and releases the core once MEM_SIZE bytes are stored.
// Revision    : 1.0 - initial release
// ============================================================================
module ice51_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int MEM_SIZE     = 512,
    parameter int AW           = 9
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    input  wire logic      i_uart_rx,
    ice51_loader_if.master mem
);

    localparam int            CW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_HALF      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_FULL      = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(MEM_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    state_t        r_state,      w_state_nxt;
    logic [CW-1:0] r_cnt,        w_cnt_nxt;
    logic [2:0]    r_bit_idx,    w_bit_idx_nxt;
    logic [7:0]    r_shift,      w_shift_nxt;
    logic [AW-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [7:0]    r_mem_data,   w_mem_data_nxt;
    logic          r_mem_we,     w_mem_we_nxt;
    logic          r_load_done,  w_load_done_nxt;
    logic          r_frame_err,  w_frame_err_nxt;
    logic          w_expired;

    // Line idles high, so both synchroniser stages reset to 1 to avoid a false start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_load_done <= w_load_done_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign w_expired = (r_cnt == '0);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_expired ? r_cnt : r_cnt - CW'(1);
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_mem_we_nxt    = 1'b0;
        w_load_done_nxt = r_load_done;
        w_frame_err_nxt = r_frame_err;

        // Address advances the cycle after the strobe; the final byte stays at MEM_SIZE-1.
        if (r_mem_we && (r_state != S_DONE)) begin
            w_mem_addr_nxt = r_mem_addr + AW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_cnt_nxt   = C_HALF;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_expired) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt     = C_FULL;
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_expired) begin
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt     = C_FULL;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_expired) begin
                    if (r_rx_s) begin
                        w_mem_data_nxt = r_shift;
                        w_mem_we_nxt   = 1'b1;
                        if (r_mem_addr == C_LAST_ADDR) begin
                            w_load_done_nxt = 1'b1;
                            w_state_nxt     = S_DONE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                // A held-low line (break) must not be taken as the next start bit.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem.o_mem_addr  = r_mem_addr;
    assign mem.o_mem_data  = r_mem_data;
    assign mem.o_mem_we    = r_mem_we;
    assign mem.o_load_done = r_load_done;
    assign mem.o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ice51_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ice51_loader
// Description : Directed self-checking bench for the UART boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ice51_loader;

    localparam int  C_CPB     = 14;
    localparam int  C_MEM     = 512;
    localparam int  C_AW      = 9;
    localparam real C_CLK_NS  = 10.0;
    localparam real C_BIT_NS  = C_CPB * C_CLK_NS;
    localparam real C_FAST_NS = C_BIT_NS * 115200.0 / 117500.0;
    localparam real C_SLOW_NS = C_BIT_NS * 115200.0 / 113000.0;

    logic clk;
    logic rst;
    logic rx;

    int n_vec;
    int n_err;

    logic [C_AW-1:0] q_addr[$];
    logic [7:0]      q_data[$];
    logic            q_done[$];

    ice51_loader_if #(.AW(C_AW)) bus ();

    ice51_loader #(
        .CLKS_PER_BIT (C_CPB),
        .MEM_SIZE     (C_MEM),
        .AW           (C_AW)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_uart_rx (rx),
        .mem       (bus.master)
    );

    initial clk = 1'b0;
    always #(C_CLK_NS / 2.0) clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_mem_we === 1'b1) begin
            q_addr.push_back(bus.o_mem_addr);
            q_data.push_back(bus.o_mem_data);
            q_done.push_back(bus.o_load_done);
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_done.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_v);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_v;
        #(bit_ns);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        #(3.0 * C_CLK_NS + 2.0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_log();
    endtask

    task automatic check_reset_values(input string tag);
        n_vec++;
        if (bus.o_mem_addr !== 9'h000) begin
            n_err++;
            $display("FAIL %s addr: got %h expected 000", tag, bus.o_mem_addr);
        end
        n_vec++;
        if (bus.o_mem_data !== 8'h00) begin
            n_err++;
            $display("FAIL %s data: got %h expected 00", tag, bus.o_mem_data);
        end
        n_vec++;
        if (bus.o_mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL %s we: got %b expected 0", tag, bus.o_mem_we);
        end
        n_vec++;
        if (bus.o_load_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s load_done: got %b expected 0", tag, bus.o_load_done);
        end
        n_vec++;
        if (bus.o_frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s frame_err: got %b expected 0", tag, bus.o_frame_err);
        end
    endtask

    task automatic check_strobe(input string tag, input int idx, input logic [8:0] ea, input logic [7:0] ed);
        n_vec++;
        if (q_addr.size() <= idx) begin
            n_err++;
            $display("FAIL %s strobe %0d missing: got %0d strobes", tag, idx, q_addr.size());
        end else if (q_addr[idx] !== ea || q_data[idx] !== ed) begin
            n_err++;
            $display("FAIL %s strobe %0d: got addr %h data %h expected addr %h data %h",
                     tag, idx, q_addr[idx], q_data[idx], ea, ed);
        end
    endtask

    task automatic check_count(input string tag, input int exp_n);
        n_vec++;
        if (q_addr.size() != exp_n) begin
            n_err++;
            $display("FAIL %s strobe count: got %0d expected %0d", tag, q_addr.size(), exp_n);
        end
    endtask

    task automatic test_reset();
        rx  = 1'b1;
        rst = 1'b1;
        #(2.0 * C_CLK_NS + 3.0);
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_log();
    endtask

    task automatic test_single_byte();
        do_reset();
        send_byte(8'hA5, C_BIT_NS, 1'b1);
        #(2.0 * C_BIT_NS);
        check_count("single", 1);
        check_strobe("single", 0, 9'h000, 8'hA5);
        n_vec++;
        if (bus.o_frame_err !== 1'b0 || bus.o_load_done !== 1'b0) begin
            n_err++;
            $display("FAIL single flags: got ferr %b done %b expected 0 0", bus.o_frame_err, bus.o_load_done);
        end
        n_vec++;
        if (bus.o_mem_addr !== 9'h001) begin
            n_err++;
            $display("FAIL single next addr: got %h expected 001", bus.o_mem_addr);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        @(posedge clk);
        #2;
        rx = 1'b0;
        #20;
        rx = 1'b1;
        #(3.0 * C_BIT_NS);
        check_count("glitch", 0);
        n_vec++;
        if (bus.o_mem_addr !== 9'h000) begin
            n_err++;
            $display("FAIL glitch addr: got %h expected 000", bus.o_mem_addr);
        end
        send_byte(8'hC3, C_BIT_NS, 1'b1);
        #(2.0 * C_BIT_NS);
        check_count("glitch follow", 1);
        check_strobe("glitch follow", 0, 9'h000, 8'hC3);
    endtask

    task automatic test_frame_error();
        do_reset();
        send_byte(8'h3C, C_BIT_NS, 1'b0);
        rx = 1'b1;
        #(2.0 * C_BIT_NS);
        check_count("frame err bad byte", 0);
        n_vec++;
        if (bus.o_frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL frame err flag: got %b expected 1", bus.o_frame_err);
        end
        send_byte(8'h5A, C_BIT_NS, 1'b1);
        #(2.0 * C_BIT_NS);
        check_count("frame err next", 1);
        check_strobe("frame err next", 0, 9'h000, 8'h5A);
        n_vec++;
        if (bus.o_frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL frame err sticky: got %b expected 1", bus.o_frame_err);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h10 + 8'(i), C_BIT_NS, 1'b1);
        end
        #(C_BIT_NS);
        check_count("midload pre", 9);
        check_strobe("midload pre", 8, 9'h008, 8'h18);
        b = 8'hFF;
        rx = 1'b0;
        #(C_BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(C_BIT_NS);
        end
        rx = b[4];
        #(C_BIT_NS / 2.0 + 3.3);
        rst = 1'b1;
        #1;
        check_reset_values("midload reset");
        rx = 1'b1;
        #20;
        @(negedge clk);
        rst = 1'b0;
        #(2.0 * C_BIT_NS);
        clear_log();
        send_byte(8'h77, C_BIT_NS, 1'b1);
        #(2.0 * C_BIT_NS);
        check_count("midload after", 1);
        check_strobe("midload after", 0, 9'h000, 8'h77);
    endtask

    task automatic test_baud_tolerance();
        logic [7:0] pat [3];
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h55;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_byte(pat[i], C_FAST_NS, 1'b1);
            #(C_FAST_NS);
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(pat[i], C_SLOW_NS, 1'b1);
            #(C_SLOW_NS);
        end
        #(2.0 * C_BIT_NS);
        check_count("baud", 6);
        for (int i = 0; i < 6; i++) begin
            check_strobe("baud", i, 9'(i), pat[i % 3]);
        end
        n_vec++;
        if (bus.o_frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL baud frame_err: got %b expected 0", bus.o_frame_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < C_MEM; i++) begin
            send_byte(8'(i), C_BIT_NS, 1'b1);
        end
        #(2.0 * C_BIT_NS);
        check_count("full load", C_MEM);
        for (int i = 0; i < C_MEM; i++) begin
            check_strobe("full load", i, 9'(i), 8'(i));
            n_vec++;
            if (i < q_done.size() && q_done[i] !== (i == C_MEM - 1)) begin
                n_err++;
                $display("FAIL full load done at strobe %0d: got %b expected %b", i, q_done[i], (i == C_MEM - 1));
            end
        end
        n_vec++;
        if (bus.o_load_done !== 1'b1) begin
            n_err++;
            $display("FAIL full load done level: got %b expected 1", bus.o_load_done);
        end
        send_byte(8'hEE, C_BIT_NS, 1'b1);
        #(2.0 * C_BIT_NS);
        check_count("extra byte", C_MEM);
        n_vec++;
        if (bus.o_mem_addr !== 9'h1FF || bus.o_load_done !== 1'b1) begin
            n_err++;
            $display("FAIL extra byte state: got addr %h done %b expected 1ff 1", bus.o_mem_addr, bus.o_load_done);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rx    = 1'b1;
        rst   = 1'b0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_reset_mid_load();
        test_baud_tolerance();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
